// File: rtl/clk_lock_rst_seq_if.sv
// Status/control bundle of the MMCM lock reset sequencer.
// master drives lock flags, mask and clear; slave (the sequencer) returns resets and status.
interface clk_lock_rst_seq_if #(
  parameter int NUM_LOCK = 4,
  parameter int CNT_W    = 8
);
  logic [NUM_LOCK-1:0] locked_in;
  logic [NUM_LOCK-1:0] lock_mask;
  logic                clr_status;
  logic [NUM_LOCK-1:0] rst_n_out;
  logic                all_ready;
  logic [2:0]          state_out;
  logic [CNT_W-1:0]    lock_loss_cnt;
  logic [NUM_LOCK-1:0] loss_sticky;

  modport master (
    output locked_in, lock_mask, clr_status,
    input  rst_n_out, all_ready, state_out, lock_loss_cnt, loss_sticky
  );

  modport slave (
    input  locked_in, lock_mask, clr_status,
    output rst_n_out, all_ready, state_out, lock_loss_cnt, loss_sticky
  );
endinterface

// File: rtl/clk_lock_rst_seq.sv
// Reset sequencer: qualifies synchronised MMCM lock flags, then releases active-low
// domain resets bit 0 first with a fixed gap; any lock loss re-asserts all and holds off.
module clk_lock_rst_seq #(
  parameter int NUM_LOCK       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP    = 16,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int CNT_W          = 8
) (
  input  logic               adc_clk100m,
  input  logic               reset,
  clk_lock_rst_seq_if.slave  bus
);
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  logic [SYNC_STAGES-1:0][NUM_LOCK-1:0] sync_q, sync_d;
  state_e                               state_q, state_d;
  logic [STAB_W-1:0]                    stab_cnt_q, stab_cnt_d;
  logic [GAP_W-1:0]                     gap_cnt_q, gap_cnt_d;
  logic [HOLD_W-1:0]                    hold_cnt_q, hold_cnt_d;
  logic [NUM_LOCK-1:0]                  rst_n_q, rst_n_d;
  logic                                 all_ready_q, all_ready_d;
  logic [CNT_W-1:0]                     loss_cnt_q, loss_cnt_d;
  logic [NUM_LOCK-1:0]                  sticky_q, sticky_d;

  logic [NUM_LOCK-1:0] locked_sync;
  logic [NUM_LOCK-1:0] rst_n_next;
  logic                all_locked;
  logic                loss;

  assign locked_sync = sync_q[SYNC_STAGES-1];
  assign all_locked  = &(locked_sync | bus.lock_mask);
  // Thermometer step: shift in one more released domain above those already out of reset.
  assign rst_n_next  = NUM_LOCK'({rst_n_q, 1'b1});

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.locked_in};
  end

  always_comb begin
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rst_n_d     = rst_n_q;
    all_ready_d = all_ready_q;
    loss_cnt_d  = bus.clr_status ? '0 : loss_cnt_q;
    sticky_d    = bus.clr_status ? '0 : sticky_q;
    loss        = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        rst_n_d     = '0;
        all_ready_d = 1'b0;
        if (all_locked) begin
          state_d    = STABLE;
          stab_cnt_d = '0;
        end
      end
      STABLE: begin
        if (!all_locked) begin
          state_d = WAIT_LOCK;
        end else if (stab_cnt_q == STAB_W'(STABLE_CYCLES - 1)) begin
          rst_n_d   = NUM_LOCK'(1);
          gap_cnt_d = '0;
          if (NUM_LOCK == 1) begin
            state_d     = RUN;
            all_ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!all_locked) begin
          loss = 1'b1;
        end else if (gap_cnt_q == GAP_W'(RELEASE_GAP - 1)) begin
          rst_n_d   = rst_n_next;
          gap_cnt_d = '0;
          if (&rst_n_next) begin
            state_d     = RUN;
            all_ready_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!all_locked) begin
          loss = 1'b1;
        end else begin
          rst_n_d     = '1;
          all_ready_d = 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Loss is applied after the clear so a coincident clr_status leaves only this event.
    if (loss) begin
      state_d     = HOLDOFF;
      hold_cnt_d  = '0;
      rst_n_d     = '0;
      all_ready_d = 1'b0;
      if (loss_cnt_d != '1) loss_cnt_d = loss_cnt_d + 1'b1;
      sticky_d    = sticky_d | (~locked_sync & ~bus.lock_mask);
    end
  end

  always_ff @(posedge adc_clk100m) begin
    if (reset) begin
      sync_q      <= '0;
      state_q     <= WAIT_LOCK;
      stab_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rst_n_q     <= '0;
      all_ready_q <= 1'b0;
      loss_cnt_q  <= '0;
      sticky_q    <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rst_n_q     <= rst_n_d;
      all_ready_q <= all_ready_d;
      loss_cnt_q  <= loss_cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.rst_n_out     = rst_n_q;
  assign bus.all_ready     = all_ready_q;
  assign bus.state_out     = state_q;
  assign bus.lock_loss_cnt = loss_cnt_q;
  assign bus.loss_sticky   = sticky_q;
endmodule

// File: tb/tb_clk_lock_rst_seq.sv
// Bench for clk_lock_rst_seq: directed release/loss/mask/clear scenarios plus random lock
// traffic, all compared cycle by cycle against a phase/timer reference model.
module tb_clk_lock_rst_seq;
  localparam int NL = 4;
  localparam int SS = 2;
  localparam int SC = 8;
  localparam int RG = 4;
  localparam int HC = 6;
  localparam int CW = 2;
  localparam int VW = 2 * NL + 4 + CW;

  logic adc_clk100m = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  clk_lock_rst_seq_if #(.NUM_LOCK(NL), .CNT_W(CW)) bus ();

  clk_lock_rst_seq #(
    .NUM_LOCK(NL), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
    .RELEASE_GAP(RG), .HOLDOFF_CYCLES(HC), .CNT_W(CW)
  ) dut (
    .adc_clk100m(adc_clk100m),
    .reset(reset),
    .bus(bus)
  );

  always #5 adc_clk100m = ~adc_clk100m;

  // Reference model: phase 0 = waiting for a long enough all-locked run, 1 = releasing/run,
  // 2 = holdoff. Lock flags seen by the sequencer are the inputs delayed SS edges.
  int            m_phase = 0;
  int            m_run = 0;
  int            m_rel = 0;
  int            m_hold = 0;
  logic [NL-1:0] m_hist[$];
  logic [NL-1:0] m_sync = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [NL-1:0] m_sticky = '0;
  logic          m_ok = 1'b0;

  always @(posedge adc_clk100m) begin
    cyc++;
    if (reset) begin
      m_phase = 0; m_run = 0; m_rel = 0; m_hold = 0;
      m_cnt = '0; m_sticky = '0;
      m_hist.delete();
      for (int i = 0; i < SS; i++) m_hist.push_back('0);
    end else begin
      m_sync = m_hist[SS-1];
      m_ok   = &(m_sync | bus.lock_mask);
      if (bus.clr_status) begin
        m_cnt = '0;
        m_sticky = '0;
      end
      case (m_phase)
        0: if (!m_ok) m_run = 0;
           else if (m_run == SC) begin m_phase = 1; m_rel = 0; end
           else m_run++;
        1: if (!m_ok) begin
             m_phase = 2; m_hold = 0;
             if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
             m_sticky = m_sticky | (~m_sync & ~bus.lock_mask);
           end else if (m_rel < 1000) m_rel++;
        default: if (m_hold == HC - 1) begin m_phase = 0; m_run = 0; end
                 else m_hold++;
      endcase
      m_hist.push_front(bus.locked_in);
      void'(m_hist.pop_back());
    end
  end

  int          e_bits;
  logic [2:0]  e_state;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] obs_vec;
  assign obs_vec = {bus.rst_n_out, bus.all_ready, bus.state_out, bus.lock_loss_cnt, bus.loss_sticky};

  always_comb begin
    e_bits  = 0;
    e_state = 3'd0;
    if (m_phase == 1) e_bits = (m_rel / RG + 1 > NL) ? NL : m_rel / RG + 1;
    if (m_phase == 2) e_state = 3'd4;
    else if (m_phase == 1) e_state = (e_bits == NL) ? 3'd3 : 3'd2;
    else e_state = (m_run > 0) ? 3'd1 : 3'd0;
    exp_vec = {NL'((1 << e_bits) - 1), e_bits == NL, e_state, m_cnt, m_sticky};
  end

  logic [31:0] exp_q[$];

  task automatic do_reset();
    reset = 1'b1;
    bus.locked_in = '0;
    bus.lock_mask = '0;
    bus.clr_status = 1'b0;
    repeat (3) @(negedge adc_clk100m);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.locked_in = '1;
    bus.lock_mask = '0;
    bus.clr_status = 1'b1;
    repeat (3) @(negedge adc_clk100m);
    total++;
    if (obs_vec !== '0) begin bad++; $display("FAIL reset_vals cyc=%0d got=%h want=0", cyc, obs_vec); end
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    bus.clr_status = 1'b0;
    bus.locked_in = '0;
    reset = 1'b0;
  endtask

  task automatic test_release();
    int e0;
    int k;
    logic [NL-1:0] prev;
    do_reset();
    bus.locked_in = '1;
    e0 = cyc + 1;
    exp_q.delete();
    for (int i = 0; i < NL; i++) exp_q.push_back(32'(e0 + SS + SC + i * RG));
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL release_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (bus.rst_n_out !== prev) begin
        k = NL - exp_q.size();
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL release_edge cyc=%0d got=%h want=no_change", cyc, bus.rst_n_out);
        end else begin
          if (cyc != exp_q[0] || bus.rst_n_out !== NL'((1 << (k + 1)) - 1)) begin
            bad++;
            $display("FAIL release_edge got cyc=%0d rst=%h want cyc=%0d rst=%h", cyc, bus.rst_n_out, exp_q[0], NL'((1 << (k + 1)) - 1));
          end
          void'(exp_q.pop_front());
        end
        prev = bus.rst_n_out;
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL release_missing got=%0d want=0 pending", exp_q.size()); end
    total++;
    if ({bus.all_ready, bus.state_out, bus.lock_loss_cnt} !== {1'b1, 3'd3, CW'(0)}) begin
      bad++; $display("FAIL release_run got=%b/%0d/%0d want=1/3/0", bus.all_ready, bus.state_out, bus.lock_loss_cnt);
    end
  endtask

  task automatic test_stable_drop();
    int e0;
    int r0;
    do_reset();
    bus.locked_in = '1;
    e0 = cyc + 1;
    while (cyc < e0 + SS + 5) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL stable_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    bus.locked_in = 4'b1011;
    repeat (3) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL stable_drop_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    total++;
    if ({bus.state_out, bus.rst_n_out, bus.lock_loss_cnt} !== {3'd0, NL'(0), CW'(0)}) begin
      bad++; $display("FAIL stable_drop got st=%0d rst=%h cnt=%0d want st=0 rst=0 cnt=0", bus.state_out, bus.rst_n_out, bus.lock_loss_cnt);
    end
    bus.locked_in = '1;
    r0 = cyc + 1;
    while (cyc < r0 + SS + SC) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL restable_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (cyc < r0 + SS + SC && bus.rst_n_out !== '0) begin
        bad++; $display("FAIL restable_early cyc=%0d got=%h want=0", cyc, bus.rst_n_out);
      end
    end
    total++;
    if (bus.rst_n_out !== NL'(1)) begin bad++; $display("FAIL restable_edge cyc=%0d got=%h want=1", cyc, bus.rst_n_out); end
  endtask

  task automatic test_run_loss();
    int d;
    do_reset();
    bus.locked_in = '1;
    for (int i = 0; i < 80 && bus.all_ready !== 1'b1; i++) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL run_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    total++;
    if (bus.all_ready !== 1'b1) begin bad++; $display("FAIL run_timeout got=%b want=1", bus.all_ready); end
    d = cyc;
    bus.locked_in = 4'b1101;
    repeat (2) @(negedge adc_clk100m);
    total++;
    if (bus.rst_n_out !== '1) begin bad++; $display("FAIL loss_early cyc=%0d got=%h want=f", cyc, bus.rst_n_out); end
    bus.locked_in = '1;
    @(negedge adc_clk100m);
    total++;
    if (obs_vec !== {NL'(0), 1'b0, 3'd4, CW'(1), NL'(4'b0010)}) begin
      bad++; $display("FAIL loss_event cyc=%0d got=%h want=%h", cyc, obs_vec, {NL'(0), 1'b0, 3'd4, CW'(1), NL'(4'b0010)});
    end
    for (int i = 1; i < HC; i++) begin
      @(negedge adc_clk100m);
      total++;
      if (bus.state_out !== 3'd4) begin bad++; $display("FAIL holdoff_state cyc=%0d got=%0d want=4", cyc, bus.state_out); end
    end
    @(negedge adc_clk100m);
    total++;
    if (bus.state_out !== 3'd0) begin bad++; $display("FAIL holdoff_exit cyc=%0d got=%0d want=0", cyc, bus.state_out); end
    while (cyc < d + 3 + HC + 1 + SC + 14) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL rerelease_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (cyc == d + 3 + HC + 1 + SC && bus.rst_n_out !== NL'(1)) begin
        bad++; $display("FAIL rerelease_edge cyc=%0d got=%h want=1", cyc, bus.rst_n_out);
      end
    end
  endtask

  task automatic test_mask();
    int e0;
    do_reset();
    bus.lock_mask = 4'b1000;
    bus.locked_in = 4'b0111;
    e0 = cyc + 1;
    for (int i = 0; i < 80 && bus.all_ready !== 1'b1; i++) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL mask_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    total++;
    if (cyc != e0 + SS + SC + (NL - 1) * RG) begin
      bad++; $display("FAIL mask_release_time got=%0d want=%0d", cyc, e0 + SS + SC + (NL - 1) * RG);
    end
    for (int i = 0; i < 12; i++) begin
      bus.locked_in[3] = 1'($urandom_range(0, 1));
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL mask_toggle_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    total++;
    if ({bus.state_out, bus.lock_loss_cnt} !== {3'd3, CW'(0)}) begin
      bad++; $display("FAIL mask_no_loss got st=%0d cnt=%0d want st=3 cnt=0", bus.state_out, bus.lock_loss_cnt);
    end
    bus.lock_mask = '0;
    bus.locked_in = '1;
  endtask

  task automatic test_saturation();
    logic [NL-1:0] drop;
    int len;
    do_reset();
    bus.locked_in = '1;
    for (int ev = 0; ev < 6; ev++) begin
      for (int i = 0; i < 80 && bus.all_ready !== 1'b1; i++) begin
        @(negedge adc_clk100m);
        total++;
        if (obs_vec !== exp_vec) begin bad++; $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      end
      total++;
      if (bus.all_ready !== 1'b1) begin bad++; $display("FAIL sat_timeout ev=%0d got=%b want=1", ev, bus.all_ready); end
      drop = NL'($urandom_range(1, (1 << NL) - 1));
      len = $urandom_range(1, 2);
      bus.locked_in = ~drop;
      for (int i = 1; i <= 3; i++) begin
        @(negedge adc_clk100m);
        total++;
        if (obs_vec !== exp_vec) begin bad++; $display("FAIL sat_loss_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        if (i == len) bus.locked_in = '1;
        bus.clr_status = (i == 2 && ev == 5);
      end
      if (ev == 4) begin
        total++;
        if (bus.lock_loss_cnt !== '1) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", bus.lock_loss_cnt, (1 << CW) - 1); end
      end
      if (ev == 5) begin
        total++;
        if ({bus.lock_loss_cnt, bus.loss_sticky} !== {CW'(1), drop}) begin
          bad++; $display("FAIL clr_vs_loss got cnt=%0d sticky=%b want cnt=1 sticky=%b", bus.lock_loss_cnt, bus.loss_sticky, drop);
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    bus.lock_mask = NL'($urandom_range(0, 3));
    for (int seg = 0; seg < 40; seg++) begin
      bus.locked_in = ($urandom_range(0, 3) != 0) ? '1 : NL'($urandom);
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        bus.clr_status = ($urandom_range(0, 15) == 0);
        @(negedge adc_clk100m);
        total++;
        if (obs_vec !== exp_vec) begin bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      end
    end
    bus.clr_status = 1'b0;
    bus.lock_mask = '0;
  endtask

  task automatic test_reset_mid();
    bus.locked_in = '1;
    for (int i = 0; i < 80 && bus.all_ready !== 1'b1; i++) @(negedge adc_clk100m);
    bus.locked_in = 4'b1110;
    @(negedge adc_clk100m);
    bus.locked_in = '1;
    for (int i = 0; i < 80 && bus.rst_n_out !== 4'b0011; i++) begin
      @(negedge adc_clk100m);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL mid_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    total++;
    if (bus.rst_n_out !== 4'b0011) begin bad++; $display("FAIL mid_timeout got=%h want=3", bus.rst_n_out); end
    total++;
    if (bus.lock_loss_cnt === '0 || bus.state_out !== 3'd2) begin
      bad++; $display("FAIL mid_precond got cnt=%0d st=%0d want cnt>0 st=2", bus.lock_loss_cnt, bus.state_out);
    end
    reset = 1'b1;
    @(negedge adc_clk100m);
    total++;
    if (obs_vec !== '0) begin bad++; $display("FAIL mid_reset_vals cyc=%0d got=%h want=0", cyc, obs_vec); end
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL mid_reset_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    reset = 1'b0;
    @(negedge adc_clk100m);
  endtask

  initial begin
    bus.locked_in = '0;
    bus.lock_mask = '0;
    bus.clr_status = 1'b0;
    @(negedge adc_clk100m);
    test_reset();
    test_release();
    test_stable_drop();
    test_run_loss();
    test_mask();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
